// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/cmov
// condition codes, the "no register" ID, and the E->M pipeline record.
package y86_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam logic [3:0] RNONE = 4'hF;

  // {ZF,SF,OF} after reset: the "zero" result.
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic            valid;
    logic [3:0]      icode;
    logic            cnd;
    logic [XLEN-1:0] val_e;
    logic [XLEN-1:0] val_a;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
  } m_reg_t;

  localparam m_reg_t M_NOP = '{
    valid: 1'b0,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: '0,
    val_a: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/execute_stage_cond_eval.sv
// Branch / conditional-move predicate from the condition codes.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of_flag,
  output logic       cnd
);

  logic lt;

  // Signed less-than is SF^OF; every other condition derives from it and ZF.
  always_comb begin
    lt  = sf ^ of_flag;
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand/function select, 64-bit ALU, condition-code
// register, cmov/jXX condition, and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             stall,
  input  logic             bubble,
  output logic [WIDTH-1:0] e_valE_fwd,
  output logic [3:0]       e_dstE_fwd,
  output logic             m_valid,
  output logic [3:0]       m_icode,
  output logic             m_Cnd,
  output logic [WIDTH-1:0] m_valE,
  output logic [WIDTH-1:0] m_valA,
  output logic [3:0]       m_dstE,
  output logic [3:0]       m_dstM,
  output logic [2:0]       cc_out
);

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

  logic [WIDTH-1:0] alu_a;      // ALU port A, fed with aluB
  logic [WIDTH-1:0] alu_b;      // ALU port B, fed with aluA
  logic [WIDTH-1:0] alu_out;
  logic             alu_of;
  alu_fun_t         alu_fun;
  logic [2:0]       cc_q;       // {ZF,SF,OF}
  logic             cond_raw;
  logic             cnd;
  logic             cc_load;
  m_reg_t           m_q;
  m_reg_t           m_d;

  // Operand and function select; port A takes aluB so subq gives valB - valA.
  always_comb begin
    alu_b   = '0;
    alu_a   = '0;
    alu_fun = ALU_ADD;
    case (e_icode)
      I_CMOV, I_OPQ:             alu_b = e_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_b = e_valC;
      I_CALL, I_PUSH:            alu_b = -STACK_STEP;
      I_RET, I_POP:              alu_b = STACK_STEP;
      default:                   alu_b = '0;
    endcase
    case (e_icode)
      I_OPQ, I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP: alu_a = e_valB;
      default:                                               alu_a = '0;
    endcase
    if (e_icode == I_OPQ) alu_fun = alu_fun_t'(e_ifun[1:0]);
  end

  // ALU; overflow is meaningful only for add/sub, logic ops clear it.
  always_comb begin
    alu_out = '0;
    alu_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_out = alu_a + alu_b;
        alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = alu_a - alu_b;
        alu_of  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  cond_eval u_cond_eval (
    .ifun    (e_ifun),
    .zf      (cc_q[2]),
    .sf      (cc_q[1]),
    .of_flag (cc_q[0]),
    .cnd     (cond_raw)
  );

  // Condition only means something for cmov/jXX; a failed cmov writes nothing.
  always_comb begin
    cnd        = ((e_icode == I_CMOV) || (e_icode == I_JXX)) && cond_raw;
    e_dstE_fwd = ((e_icode == I_CMOV) && !cnd) ? RNONE : e_dstE;
    e_valE_fwd = alu_out;
    cc_load    = e_valid && (e_icode == I_OPQ) && !stall && !bubble;
  end

  // Next M record: an invalid instruction travels as a nop.
  always_comb begin
    m_d = M_NOP;
    if (e_valid && !bubble) begin
      m_d.valid = 1'b1;
      m_d.icode = e_icode;
      m_d.cnd   = cnd;
      m_d.val_e = alu_out;
      m_d.val_a = e_valA;
      m_d.dst_e = e_dstE_fwd;
      m_d.dst_m = e_dstM;
    end
  end

  // Condition codes: only an OPq that actually advances updates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (cc_load) begin
      cc_q <= {(alu_out == '0), alu_out[WIDTH-1], alu_of};
    end
  end

  // E->M register; stall outranks bubble, reset outranks both.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= M_NOP;
    end else if (!stall) begin
      m_q <= m_d;
    end
  end

  // Drive the named M outputs from the packed record.
  always_comb begin
    m_valid = m_q.valid;
    m_icode = m_q.icode;
    m_Cnd   = m_q.cnd;
    m_valE  = m_q.val_e;
    m_valA  = m_q.val_a;
    m_dstE  = m_q.dst_e;
    m_dstM  = m_q.dst_m;
    cc_out  = cc_q;
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valA;
  logic [63:0] e_valB;
  logic [63:0] e_valC;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        stall;
  logic        bubble;
  logic [63:0] e_valE_fwd;
  logic [3:0]  e_dstE_fwd;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic        m_Cnd;
  logic [63:0] m_valE;
  logic [63:0] m_valA;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [2:0]  cc_out;

  execute_stage #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .e_valid    (e_valid),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_valA     (e_valA),
    .e_valB     (e_valB),
    .e_valC     (e_valC),
    .e_dstE     (e_dstE),
    .e_dstM     (e_dstM),
    .stall      (stall),
    .bubble     (bubble),
    .e_valE_fwd (e_valE_fwd),
    .e_dstE_fwd (e_dstE_fwd),
    .m_valid    (m_valid),
    .m_icode    (m_icode),
    .m_Cnd      (m_Cnd),
    .m_valE     (m_valE),
    .m_valA     (m_valA),
    .m_dstE     (m_dstE),
    .m_dstM     (m_dstM),
    .cc_out     (cc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected M outputs and CC.
  logic        x_valid;
  logic [3:0]  x_icode;
  logic        x_cnd;
  logic [63:0] x_valE;
  logic [63:0] x_valA;
  logic [3:0]  x_dstE;
  logic [3:0]  x_dstM;
  logic        x_zf, x_sf, x_of;
  // Model combinational results for the inputs currently driven.
  logic [63:0] c_valE;
  logic [3:0]  c_dstE;
  logic        c_cnd;
  logic        c_of;

  localparam logic [63:0] MINUS8 = 64'hFFFF_FFFF_FFFF_FFF8;

  function automatic logic [144:0] m_now();
    return {m_valid, m_icode, m_Cnd, m_valE, m_valA, m_dstE, m_dstM, cc_out};
  endfunction

  function automatic logic [144:0] m_exp();
    return {x_valid, x_icode, x_cnd, x_valE, x_valA, x_dstE, x_dstM, x_zf, x_sf, x_of};
  endfunction

  task automatic model_nop();
    x_valid = 1'b0; x_icode = 4'h1; x_cnd = 1'b0; x_valE = '0; x_valA = '0;
    x_dstE = 4'hF; x_dstM = 4'hF;
  endtask

  // Y86 execute semantics in plain arithmetic, from the current inputs and model CC.
  task automatic model_eval();
    logic [63:0] opa, opb;
    logic signed [64:0] wide;
    logic lt, pred;
    opa = 64'd0;
    opb = 64'd0;
    if (e_icode == 4'h2 || e_icode == 4'h6) opa = e_valA;
    else if (e_icode inside {4'h3, 4'h4, 4'h5}) opa = e_valC;
    else if (e_icode == 4'h8 || e_icode == 4'hA) opa = MINUS8;
    else if (e_icode == 4'h9 || e_icode == 4'hB) opa = 64'd8;
    if (e_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) opb = e_valB;
    c_of = 1'b0;
    if (e_icode == 4'h6 && e_ifun[1:0] == 2'd1) begin
      wide   = $signed({opb[63], opb}) - $signed({opa[63], opa});
      c_valE = wide[63:0];
      c_of   = wide[64] ^ wide[63];
    end else if (e_icode == 4'h6 && e_ifun[1:0] == 2'd2) begin
      c_valE = opb & opa;
    end else if (e_icode == 4'h6 && e_ifun[1:0] == 2'd3) begin
      c_valE = opb ^ opa;
    end else begin
      wide   = $signed({opb[63], opb}) + $signed({opa[63], opa});
      c_valE = wide[63:0];
      c_of   = wide[64] ^ wide[63];
    end
    lt = (x_sf != x_of);
    case (e_ifun)
      4'd0: pred = 1'b1;
      4'd1: pred = lt || x_zf;
      4'd2: pred = lt;
      4'd3: pred = x_zf;
      4'd4: pred = !x_zf;
      4'd5: pred = !lt;
      4'd6: pred = !lt && !x_zf;
      default: pred = 1'b0;
    endcase
    c_cnd  = (e_icode == 4'h2 || e_icode == 4'h7) ? pred : 1'b0;
    c_dstE = (e_icode == 4'h2 && !c_cnd) ? 4'hF : e_dstE;
  endtask

  // Advance one clock and update the model with the pipeline-register rules.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      model_nop();
      {x_zf, x_sf, x_of} = 3'b100;
    end else if (stall) begin
      // hold
    end else if (bubble || !e_valid) begin
      model_nop();
    end else begin
      if (e_icode == 4'h6) begin
        x_zf = (c_valE == 64'd0);
        x_sf = c_valE[63];
        x_of = c_of;
      end
      x_valid = 1'b1; x_icode = e_icode; x_cnd = c_cnd; x_valE = c_valE;
      x_valA = e_valA; x_dstE = c_dstE; x_dstM = e_dstM;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic st, input logic bu, input logic r);
    e_valid = v; e_icode = ic; e_ifun = fn; e_valA = a; e_valB = b; e_valC = c;
    e_dstE = de; e_dstM = dm; stall = st; bubble = bu; rst = r;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_now() !== {1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b100}) begin
      n_bad++;
      $display("FAIL reset_state: got %h want nop/cc=100", m_now());
    end
  endtask

  task automatic test_sub_eq();
    drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
    #1; model_eval();
    n_cmp++;
    if (e_valE_fwd !== 64'd0) begin
      n_bad++; $display("FAIL sub_fwd: got %h want 0", e_valE_fwd);
    end
    tick();
    n_cmp++;
    if (m_valE !== 64'd0 || cc_out !== 3'b100 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL sub_eq: got %h want %h", m_now(), m_exp());
    end
    drive(1'b1, 4'h7, 4'h3, 64'd0, 64'd0, 64'h400, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_Cnd !== 1'b1 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL je_taken: got Cnd %b want 1", m_Cnd);
    end
  endtask

  task automatic test_add_overflow_cmov();
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF,
          1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_valE !== 64'h8000_0000_0000_0000 || cc_out !== 3'b011) begin
      n_bad++; $display("FAIL add_ovf: got valE %h cc %b want 8000000000000000 011",
                        m_valE, cc_out);
    end
    // cmovl with SF=OF=1 is not taken, so the forwarded destination is dropped.
    drive(1'b1, 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
    #1; model_eval();
    n_cmp++;
    if ({e_valE_fwd, e_dstE_fwd} !== {64'h55, 4'hF}) begin
      n_bad++; $display("FAIL cmovl_fwd: got %h/%h want 55/f", e_valE_fwd, e_dstE_fwd);
    end
    tick();
    n_cmp++;
    if (m_Cnd !== 1'b0 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL cmovl_m: got %h want %h", m_now(), m_exp());
    end
  endtask

  task automatic test_stack_addr();
    logic [2:0] cc0;
    cc0 = cc_out;
    drive(1'b1, 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_valE !== 64'hF8 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL pushq: got valE %h want f8", m_valE);
    end
    drive(1'b1, 4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_valE !== 64'h108 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL popq: got valE %h want 108", m_valE);
    end
    drive(1'b1, 4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 4'hF, 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_valE !== 64'h30 || cc_out !== cc0 || m_now() !== m_exp()) begin
      n_bad++; $display("FAIL mrmovq: got valE %h cc %b want 30 %b", m_valE, cc_out, cc0);
    end
  endtask

  task automatic test_stall_bubble();
    logic [144:0] prev;
    prev = m_now();
    drive(1'b1, 4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0, 4'h1, 4'hF, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (m_now() !== prev) begin
      n_bad++; $display("FAIL stall_hold: got %h want %h", m_now(), prev);
    end
    drive(1'b1, 4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (m_icode !== 4'h1 || m_valid !== 1'b0 || cc_out !== prev[2:0]) begin
      n_bad++; $display("FAIL bubble: got icode %h valid %b cc %b want 1 0 %b",
                        m_icode, m_valid, cc_out, prev[2:0]);
    end
  endtask

  task automatic test_and_reset();
    drive(1'b1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (m_valE !== 64'd0 || cc_out[2] !== 1'b1 || cc_out[0] !== 1'b0) begin
      n_bad++; $display("FAIL andq: got valE %h cc %b want 0 1x0", m_valE, cc_out);
    end
    drive(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
          4'h7, 4'hF, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (m_now() !== {1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b100}) begin
      n_bad++; $display("FAIL reset_mid: got %h want nop/cc=100", m_now());
    end
  endtask

  task automatic test_random();
    logic [63:0] ra, rb, rc;
    logic [3:0]  ic, fn;
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = rb;
        1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        2: rb = 64'h8000_0000_0000_0000;
        3: ra = 64'd1;
        default: ;
      endcase
      ic = 4'($urandom_range(0, 11));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      drive($urandom_range(0, 9) != 0, ic, fn, ra, rb, rc,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0);
      #1; model_eval();
      n_cmp++;
      if ({e_valE_fwd, e_dstE_fwd} !== {c_valE, c_dstE}) begin
        n_bad++; $display("FAIL rnd_fwd[%0d]: got %h/%h want %h/%h",
                          i, e_valE_fwd, e_dstE_fwd, c_valE, c_dstE);
      end
      tick();
      n_cmp++;
      if (m_now() !== m_exp()) begin
        n_bad++; $display("FAIL rnd_m[%0d]: got %h want %h", i, m_now(), m_exp());
      end
    end
  endtask

  initial begin
    model_nop();
    {x_zf, x_sf, x_of} = 3'b100;
    drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    #1;
    test_reset();
    test_sub_eq();
    test_add_overflow_cmov();
    test_stack_addr();
    test_stall_bubble();
    test_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
